// File: rtl/sqrt_ctrl_pkg.sv
// Shared definitions for the square-root controller: state encoding and
// default watchdog limit.
package sqrt_ctrl_pkg;

  localparam int STATE_W          = 2;
  localparam int DEFAULT_MAX_ITER = 16;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    TEST = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_e;

endpackage

// File: rtl/sqrt_iter_counter.sv
// Saturating iteration counter for the square-root controller.
// Ports:
//   clk, clr  - clock, async active-high clear
//   clear     - synchronous clear (start of a run)
//   inc       - count one add iteration (ignored once at MAX_ITER)
//   cnt       - current count
//   limit     - cnt == MAX_ITER
module sqrt_iter_counter
  import sqrt_ctrl_pkg::*;
#(
  parameter int MAX_ITER = DEFAULT_MAX_ITER,
  parameter int ITER_W   = 5
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              clear,
  input  logic              inc,
  output logic [ITER_W-1:0] cnt,
  output logic              limit
);

  localparam logic [ITER_W-1:0] MAX_CNT = ITER_W'(MAX_ITER);
  localparam logic [ITER_W-1:0] ONE     = ITER_W'(1);

  logic [ITER_W-1:0] cnt_r;

  // Count register: clear wins over increment, and the count never wraps.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (inc && (cnt_r != MAX_CNT)) begin
      cnt_r <= cnt_r + ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt   = cnt_r;
  assign limit = (cnt_r == MAX_CNT);

endmodule

// File: rtl/sqrt_controller.sv
// Control FSM for the 8-bit iterative square-root datapath.
// Ports:
//   clk, clr          - clock, async active-high reset (shared with datapath)
//   start/ack/abort   - requester handshake
//   greater           - datapath flag a_q < sq_q
//   en_a/en_del/en_sq/en_out, ld_add - datapath enables (combinational)
//   busy/done/err     - registered status, one-hot-or-zero
//   iter_cnt          - add iterations in the current or last run
module sqrt_controller
  import sqrt_ctrl_pkg::*;
#(
  parameter int MAX_ITER = DEFAULT_MAX_ITER,
  parameter int ITER_W   = 5
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic              ack,
  input  logic              abort,
  input  logic              greater,
  output logic              en_a,
  output logic              en_del,
  output logic              en_sq,
  output logic              en_out,
  output logic              ld_add,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ITER_W-1:0] iter_cnt
);

  state_e state_r, state_nxt_s;
  logic   busy_r, done_r, err_r;
  logic   busy_nxt_s, done_nxt_s, err_nxt_s;
  logic   en_a_s, en_del_s, en_sq_s, en_out_s, ld_add_s;
  logic   cnt_clear_s, cnt_inc_s, limit_s;

  sqrt_iter_counter #(
    .MAX_ITER (MAX_ITER),
    .ITER_W   (ITER_W)
  ) u_iter_counter (
    .clk   (clk),
    .clr   (clr),
    .clear (cnt_clear_s),
    .inc   (cnt_inc_s),
    .cnt   (iter_cnt),
    .limit (limit_s)
  );

  // State and status registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
      err_r   <= err_nxt_s;
    end
  end

  // Next-state, status and datapath-enable decode.
  always_comb begin
    state_nxt_s = state_r;
    busy_nxt_s  = busy_r;
    done_nxt_s  = done_r;
    err_nxt_s   = err_r;
    en_a_s      = 1'b0;
    en_del_s    = 1'b0;
    en_sq_s     = 1'b0;
    en_out_s    = 1'b0;
    ld_add_s    = 1'b0;
    cnt_clear_s = 1'b0;
    cnt_inc_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          en_a_s      = 1'b1;
          en_del_s    = 1'b1;
          en_sq_s     = 1'b1;
          cnt_clear_s = 1'b1;
          busy_nxt_s  = 1'b1;
          state_nxt_s = TEST;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      TEST: begin
        // Abort outranks greater so an aborted run never touches out.
        if (abort) begin
          busy_nxt_s  = 1'b0;
          state_nxt_s = IDLE;
        end else if (greater) begin
          en_out_s    = 1'b1;
          busy_nxt_s  = 1'b0;
          done_nxt_s  = 1'b1;
          state_nxt_s = DONE;
        end else if (limit_s) begin
          busy_nxt_s  = 1'b0;
          err_nxt_s   = 1'b1;
          state_nxt_s = ERR;
        end else begin
          ld_add_s    = 1'b1;
          en_del_s    = 1'b1;
          en_sq_s     = 1'b1;
          cnt_inc_s   = 1'b1;
          state_nxt_s = TEST;
        end
      end
      DONE: begin
        if (ack) begin
          done_nxt_s  = 1'b0;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      ERR: begin
        if (ack) begin
          err_nxt_s   = 1'b0;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = ERR;
        end
      end
      default: begin
        busy_nxt_s  = 1'b0;
        done_nxt_s  = 1'b0;
        err_nxt_s   = 1'b0;
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Enables are masked by clr so the datapath sees no load while reset is held.
  assign en_a   = en_a_s   & ~clr;
  assign en_del = en_del_s & ~clr;
  assign en_sq  = en_sq_s  & ~clr;
  assign en_out = en_out_s & ~clr;
  assign ld_add = ld_add_s & ~clr;

  assign busy = busy_r;
  assign done = done_r;
  assign err  = err_r;

endmodule

// File: doc/sqrt_controller.md
Name: sqrt_controller

Overview:
- Control FSM that sequences the 8-bit iterative square-root datapath (a/del/sq/out registers) through load, add-iterate, compare and capture.
- Sits between the external requester (start/ack/abort handshake) and the datapath enables. It consumes the datapath's `greater` flag.
- Adds an iteration counter and a watchdog, so a stuck or misconfigured datapath raises `err` instead of looping forever.

Parameters:
- MAX_ITER, 16, watchdog limit on add iterations. An 8-bit input needs at most 15.
- ITER_W, 5, width of iter_cnt. Must satisfy 2^ITER_W > MAX_ITER.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  reset, asynchronous, active-high; same net as datapath clr.
- start  in  1  request new computation; sampled only in IDLE.
- ack  in  1  requester acknowledges done/err; sampled only in DONE/ERR.
- abort  in  1  cancel a computation in progress; sampled only in TEST.
- greater  in  1  datapath flag, a_q < sq_q.
- en_a  out  1  load a register.
- en_del  out  1  load del register.
- en_sq  out  1  load sq register.
- en_out  out  1  load out register (captures sqrt).
- ld_add  out  1  1 = accumulate (del+=2, sq+=del); 0 = init (del=3, sq=1).
- busy  out  1  computation in progress.
- done  out  1  result valid on datapath sqrt; level, held until ack.
- err  out  1  watchdog tripped; level, held until ack.
- iter_cnt  out  ITER_W  add iterations performed in the current or last run.

Behaviour:
- Reset (clr=1, async): state=IDLE, iter_cnt=0, busy=done=err=0. All enables and ld_add are 0 while clr is high.
- Enables are combinational from state, start, greater, abort and iter_cnt. busy/done/err/iter_cnt are registered.
- IDLE:
  - start=1 → en_a=en_del=en_sq=1, ld_add=0. This loads a, sets del=3 and sq=1.
  - Same edge: iter_cnt←0, busy←1, next state TEST.
  - start=0 → all enables 0; stay in IDLE.
- TEST, checked in priority order:
  - abort=1 → all enables 0; next IDLE, busy←0. Abort beats greater, so out is not updated.
  - greater=1 → en_out=1; next DONE, busy←0, done←1.
  - greater=0 and iter_cnt==MAX_ITER → all enables 0; next ERR, busy←0, err←1.
  - Otherwise → ld_add=1, en_del=en_sq=1, iter_cnt←iter_cnt+1; stay in TEST.
- DONE: all enables 0. ack=1 → next IDLE, done←0. A start in the same cycle is ignored and must be reasserted. iter_cnt holds.
- ERR: all enables 0. ack=1 → next IDLE, err←0.
- Latency: with k = floor(sqrt(a)), the run performs k adds. done is high after rising edge k+1, where the start edge is edge 0. Examples: a=0 gives done after edge 1; a=255 gives done after edge 16.
- Resulting sqrt = (del>>1)-1 with del=2k+3, which is exact floor sqrt for 0..255.
- iter_cnt saturates at MAX_ITER; it never wraps.
- Invariants: busy, done and err are one-hot-or-zero. ld_add=1 only in the TEST add branch. en_a=1 only on the IDLE→TEST edge.
- clr mid-run: immediate return to IDLE. Datapath registers are cleared by the same clr.

Decomposition:
- sqrt_ctrl_pkg holds the state enum {IDLE, TEST, DONE, ERR}, the 2-bit state width, and DEFAULT_MAX_ITER=16.
- One sub-module, sqrt_iter_counter:
  - Saturating ITER_W counter with clear/inc inputs.
  - Output `limit` = (cnt==MAX_ITER).
  - Same clk/clr.

Test Plan:
- a=0, start pulse → edge0 load; edge1 en_out; done=1, sqrt=0, iter_cnt=0; ack → IDLE with done=0.
- a=255 → 15 cycles of ld_add=1; done after edge 16, sqrt=15, iter_cnt=15, err=0.
- Sweep a=0..255 back-to-back with ack immediately after done → sqrt==floor(sqrt(a)) and iter_cnt==sqrt every run; start asserted during TEST is ignored.
- MAX_ITER=4, a=100 → after 4 adds, err=1, en_out never asserted, iter_cnt=4; ack → IDLE.
- a=200, abort in 3rd TEST cycle with greater=0 → no en_out, next state IDLE, busy=0, done=0. Also force abort and greater high in the same cycle → en_out stays 0.
- a=50, assert clr asynchronously mid-TEST → outputs drop to 0 without waiting for a clock edge; a fresh start afterwards yields sqrt=7.
